// File: rtl/ram2e_host.sv
// Apple IIe auxiliary-slot bus initiator that exercises a RAM2E card: PHI1, muxed
// DRAM addresses, control strobes, read/video capture and the RAMWorks $C073 sequence.
module ram2e_host #(
    parameter bit LONG_CYCLE = 1'b1
) (
    input  logic        C14M,
    input  logic        Reset,
    output logic        PHI1,
    output logic [7:0]  Ain,
    output logic [7:0]  Din,
    output logic        nEN80,
    output logic        nWE80,
    output logic        nWE,
    output logic        nC07X,
    input  logic [7:0]  Dout,
    input  logic [7:0]  Vout,
    input  logic [15:0] VA,
    output logic [7:0]  VData,
    output logic        VValid,
    input  logic        Req,
    input  logic        ReqWE,
    input  logic        ReqAux,
    input  logic [15:0] ReqA,
    input  logic [7:0]  ReqD,
    output logic        Ack,
    output logic [7:0]  RData,
    output logic        RValid,
    input  logic        CmdReq,
    input  logic [7:0]  CmdByte,
    input  logic [7:0]  CmdArg,
    input  logic        CmdHasArg,
    output logic        CmdBusy,
    output logic        CmdDone
);
    localparam int unsigned T_W   = 4;
    localparam int unsigned CYC_W = 7;
    localparam int unsigned K_W   = 3;
    localparam logic [T_W-1:0]   T_END      = T_W'(13);
    localparam logic [T_W-1:0]   T_LONG_END = T_W'(15);
    localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(64);
    localparam logic [15:0]      CMD_ADDR   = 16'hC073;

    typedef enum logic {S_IDLE, S_SEQ} seq_state_t;

    seq_state_t     r_state, w_state_n;
    logic [T_W-1:0] r_t, w_t_n;
    logic [CYC_W-1:0] r_cyc, w_cyc_n;
    logic [K_W-1:0] r_k, w_k_n, w_k_eff, w_k_last;
    logic [7:0]     r_cmd_byte, w_cmd_byte_n, r_cmd_arg, w_cmd_arg_n;
    logic           r_has_arg, w_has_arg_n;
    logic [15:0]    r_va, w_va_n;
    logic           r_slot_cpu, w_slot_cpu_n, r_slot_seq, w_slot_seq_n;
    logic           r_we, w_we_n, r_aux, w_aux_n;
    logic [15:0]    r_a, w_a_n;
    logic [7:0]     r_d, w_d_n;
    logic           w_long, w_seq_go, w_act, w_done_n;
    logic [7:0]     w_seq_byte;

    logic           r_phi1, w_phi1_n;
    logic [7:0]     r_ain, w_ain_n, r_din, w_din_n;
    logic           r_nen80, w_nen80_n, r_nwe80, w_nwe80_n, r_nwe, w_nwe_n, r_nc07x, w_nc07x_n;
    logic [7:0]     r_vdata, w_vdata_n, r_rdata, w_rdata_n;
    logic           r_vvalid, w_vvalid_n, r_ack, w_ack_n, r_rvalid, w_rvalid_n;
    logic           r_busy, w_busy_n, r_done;

    // RAMWorks unlock preamble followed by the command and optional argument
    always_comb begin
        w_k_eff = (r_state == S_IDLE) ? '0 : r_k;
        case (w_k_eff)
            K_W'(0): w_seq_byte = 8'hFF;
            K_W'(1): w_seq_byte = 8'h00;
            K_W'(2): w_seq_byte = 8'h55;
            K_W'(3): w_seq_byte = 8'hAA;
            K_W'(4): w_seq_byte = 8'hC1;
            K_W'(5): w_seq_byte = 8'hAD;
            K_W'(6): w_seq_byte = r_cmd_byte;
            default: w_seq_byte = r_cmd_arg;
        endcase
    end

    always_comb begin
        w_long  = LONG_CYCLE && (r_cyc == LAST_CYC);
        w_t_n   = r_t + T_W'(1);
        w_cyc_n = r_cyc;
        if (r_t == (w_long ? T_LONG_END : T_END)) begin
            w_t_n   = '0;
            w_cyc_n = (r_cyc == LAST_CYC) ? '0 : r_cyc + CYC_W'(1);
        end
        w_va_n = (r_t == T_W'(12)) ? VA : r_va;

        w_state_n    = r_state;
        w_k_n        = r_k;
        w_cmd_byte_n = r_cmd_byte;
        w_cmd_arg_n  = r_cmd_arg;
        w_has_arg_n  = r_has_arg;
        w_done_n     = 1'b0;
        w_k_last     = r_has_arg ? K_W'(7) : K_W'(6);
        w_seq_go     = (r_state == S_SEQ) || ((r_state == S_IDLE) && CmdReq);
        if ((r_state == S_IDLE) && CmdReq) begin
            w_state_n    = S_SEQ;
            w_k_n        = '0;
            w_cmd_byte_n = CmdByte;
            w_cmd_arg_n  = CmdArg;
            w_has_arg_n  = CmdHasArg;
        end
        if ((r_t == T_W'(12)) && r_slot_seq) begin
            if (r_k == w_k_last) begin
                w_state_n = S_IDLE;
                w_done_n  = 1'b1;
            end else begin
                w_k_n = r_k + K_W'(1);
            end
        end

        // slot ownership is settled at the edge ending T4; the sequencer has priority
        w_slot_cpu_n = r_slot_cpu;
        w_slot_seq_n = r_slot_seq;
        w_we_n       = r_we;
        w_aux_n      = r_aux;
        w_a_n        = r_a;
        w_d_n        = r_d;
        w_ack_n      = 1'b0;
        if (r_t == T_W'(4)) begin
            w_slot_seq_n = w_seq_go;
            w_slot_cpu_n = !w_seq_go && Req;
            w_ack_n      = !w_seq_go && Req;
            if (w_seq_go) begin
                w_we_n = 1'b1; w_aux_n = 1'b0; w_a_n = CMD_ADDR; w_d_n = w_seq_byte;
            end else if (Req) begin
                w_we_n = ReqWE; w_aux_n = ReqAux; w_a_n = ReqA; w_d_n = ReqD;
            end else begin
                w_we_n = 1'b0; w_aux_n = 1'b0; w_a_n = '0; w_d_n = '0;
            end
        end

        w_act     = (w_slot_cpu_n || w_slot_seq_n) && (w_t_n >= T_W'(5)) && (w_t_n <= T_W'(12));
        w_phi1_n  = (w_t_n <= T_W'(6));
        case (w_t_n)
            T_W'(1), T_W'(2), T_W'(3), T_W'(4):           w_ain_n = w_va_n[15:8];
            T_W'(5), T_W'(6), T_W'(7):                    w_ain_n = w_a_n[7:0];
            T_W'(8), T_W'(9), T_W'(10), T_W'(11), T_W'(12): w_ain_n = w_a_n[15:8];
            default:                                      w_ain_n = w_va_n[7:0];
        endcase
        w_nwe_n    = w_act ? !w_we_n : 1'b1;
        w_nen80_n  = w_act ? !w_aux_n : 1'b1;
        w_nwe80_n  = w_act ? !(w_aux_n && w_we_n) : 1'b1;
        w_nc07x_n  = w_act ? (w_a_n[15:4] != 12'hC07) : 1'b1;
        w_din_n    = (w_act && w_we_n) ? w_d_n : 8'h00;
        w_rdata_n  = ((r_t == T_END) && r_slot_cpu && r_aux && !r_we) ? Dout : r_rdata;
        w_rvalid_n = (w_t_n == '0) && r_slot_cpu && r_aux && !r_we;
        w_vdata_n  = (r_t == T_W'(8)) ? Vout : r_vdata;
        w_vvalid_n = (w_t_n == T_W'(9));
        w_busy_n   = (w_state_n == S_SEQ);
    end

    always_ff @(posedge C14M) begin
        if (Reset) begin
            r_state <= S_IDLE;   r_t <= T_W'(7);    r_cyc <= '0;       r_k <= '0;
            r_cmd_byte <= '0;    r_cmd_arg <= '0;   r_has_arg <= 1'b0; r_va <= '0;
            r_slot_cpu <= 1'b0;  r_slot_seq <= 1'b0; r_we <= 1'b0;     r_aux <= 1'b0;
            r_a <= '0;           r_d <= '0;         r_phi1 <= 1'b0;    r_ain <= '0;
            r_din <= '0;         r_nen80 <= 1'b1;   r_nwe80 <= 1'b1;   r_nwe <= 1'b1;
            r_nc07x <= 1'b1;     r_vdata <= '0;     r_rdata <= '0;     r_vvalid <= 1'b0;
            r_ack <= 1'b0;       r_rvalid <= 1'b0;  r_busy <= 1'b0;    r_done <= 1'b0;
        end else begin
            r_state <= w_state_n;   r_t <= w_t_n;           r_cyc <= w_cyc_n;         r_k <= w_k_n;
            r_cmd_byte <= w_cmd_byte_n; r_cmd_arg <= w_cmd_arg_n; r_has_arg <= w_has_arg_n; r_va <= w_va_n;
            r_slot_cpu <= w_slot_cpu_n; r_slot_seq <= w_slot_seq_n; r_we <= w_we_n;   r_aux <= w_aux_n;
            r_a <= w_a_n;           r_d <= w_d_n;           r_phi1 <= w_phi1_n;       r_ain <= w_ain_n;
            r_din <= w_din_n;       r_nen80 <= w_nen80_n;   r_nwe80 <= w_nwe80_n;     r_nwe <= w_nwe_n;
            r_nc07x <= w_nc07x_n;   r_vdata <= w_vdata_n;   r_rdata <= w_rdata_n;     r_vvalid <= w_vvalid_n;
            r_ack <= w_ack_n;       r_rvalid <= w_rvalid_n; r_busy <= w_busy_n;       r_done <= w_done_n;
        end
    end

    assign PHI1 = r_phi1;     assign Ain = r_ain;       assign Din = r_din;
    assign nEN80 = r_nen80;   assign nWE80 = r_nwe80;   assign nWE = r_nwe;     assign nC07X = r_nc07x;
    assign VData = r_vdata;   assign VValid = r_vvalid; assign Ack = r_ack;
    assign RData = r_rdata;   assign RValid = r_rvalid; assign CmdBusy = r_busy; assign CmdDone = r_done;
endmodule

// File: tb/tb_ram2e_host.sv
// Randomized bench for ram2e_host; a timeline model derived from clock position
// predicts every output on every C14M cycle.
module tb_ram2e_host;
    localparam bit LONG = 1'b1;
    localparam int FRAME = 65 * 14 + (LONG ? 2 : 0);

    logic        C14M, Reset;
    logic        PHI1;
    logic [7:0]  Ain, Din;
    logic        nEN80, nWE80, nWE, nC07X;
    logic [7:0]  Dout, Vout;
    logic [15:0] VA;
    logic [7:0]  VData;
    logic        VValid;
    logic        Req, ReqWE, ReqAux;
    logic [15:0] ReqA;
    logic [7:0]  ReqD;
    logic        Ack;
    logic [7:0]  RData;
    logic        RValid;
    logic        CmdReq;
    logic [7:0]  CmdByte, CmdArg;
    logic        CmdHasArg, CmdBusy, CmdDone;

    ram2e_host #(.LONG_CYCLE(LONG)) dut (
        .C14M(C14M), .Reset(Reset), .PHI1(PHI1), .Ain(Ain), .Din(Din),
        .nEN80(nEN80), .nWE80(nWE80), .nWE(nWE), .nC07X(nC07X),
        .Dout(Dout), .Vout(Vout), .VA(VA), .VData(VData), .VValid(VValid),
        .Req(Req), .ReqWE(ReqWE), .ReqAux(ReqAux), .ReqA(ReqA), .ReqD(ReqD),
        .Ack(Ack), .RData(RData), .RValid(RValid),
        .CmdReq(CmdReq), .CmdByte(CmdByte), .CmdArg(CmdArg), .CmdHasArg(CmdHasArg),
        .CmdBusy(CmdBusy), .CmdDone(CmdDone)
    );

    initial C14M = 1'b0;
    always #35 C14M = ~C14M;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;
    int cur_t = 7;

    // model state
    logic [7:0]  preamble [6] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};
    logic [7:0]  m_q [$];
    logic [7:0]  seq_obs [$];
    bit          m_busy, m_done;
    int          m_kind;               // 0 idle, 1 CPU, 2 sequencer
    logic        m_we, m_aux;
    logic [15:0] m_a, m_va;
    logic [7:0]  m_d, m_vdata, m_rdata;
    int          m_seq_writes;
    bit          dout_force = 1'b0;
    logic [7:0]  dout_val = 8'h00;

    function automatic int phase_t(input int nn);
        int q;
        q = (nn + 7) % FRAME;
        return (q < 64 * 14) ? (q % 14) : (q - 64 * 14);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h (t=%0d n=%0d)", tag, obs, exp, cur_t, n);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 1'b0; m_done = 1'b0; m_kind = 0;
        m_we = 1'b0; m_aux = 1'b0; m_a = '0; m_d = '0;
        m_va = '0; m_vdata = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (!m_busy && CmdReq) begin
            m_busy = 1'b1;
            m_q.delete();
            foreach (preamble[i]) m_q.push_back(preamble[i]);
            m_q.push_back(CmdByte);
            if (CmdHasArg) m_q.push_back(CmdArg);
        end
        case (cur_t)
            4: begin
                if (m_busy) begin
                    m_kind = 2; m_a = 16'hC073; m_we = 1'b1; m_aux = 1'b0;
                    m_d = m_q.pop_front(); m_seq_writes++;
                end else if (Req) begin
                    m_kind = 1; m_a = ReqA; m_we = ReqWE; m_aux = ReqAux; m_d = ReqD;
                end else begin
                    m_kind = 0;
                end
            end
            8:  m_vdata = Vout;
            12: begin
                m_va = VA;
                if (m_kind == 2 && m_busy && m_q.size() == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
            13: if (m_kind == 1 && m_aux && !m_we) m_rdata = Dout;
            default: ;
        endcase
    endtask

    task automatic check_reset();
        check("rst_phi1", 32'(PHI1), 0);
        check("rst_ain", 32'(Ain), 0);
        check("rst_din", 32'(Din), 0);
        check("rst_strobes", 32'({nEN80, nWE80, nWE, nC07X}), 32'hF);
        check("rst_flags", 32'({Ack, RValid, VValid, CmdBusy, CmdDone}), 0);
        check("rst_rdata", 32'(RData), 0);
        check("rst_vdata", 32'(VData), 0);
    endtask

    task automatic check_outputs();
        bit act;
        act = (m_kind != 0) && cur_t >= 5 && cur_t <= 12;
        check("phi1", 32'(PHI1), 32'(cur_t <= 6));
        if (cur_t >= 13 || cur_t == 0) check("ain_vrow", 32'(Ain), 32'(m_va[7:0]));
        else if (cur_t <= 4)           check("ain_vcol", 32'(Ain), 32'(m_va[15:8]));
        else if (m_kind != 0)          check("ain_cpu", 32'(Ain), 32'(cur_t <= 7 ? m_a[7:0] : m_a[15:8]));
        check("nwe", 32'(nWE), 32'(act ? !m_we : 1'b1));
        check("nen80", 32'(nEN80), 32'(act ? !m_aux : 1'b1));
        check("nwe80", 32'(nWE80), 32'(act ? !(m_aux && m_we) : 1'b1));
        check("nc07x", 32'(nC07X), 32'(act ? (m_a[15:4] != 12'hC07) : 1'b1));
        check("din", 32'(Din), 32'((act && m_we) ? m_d : 8'h00));
        check("ack", 32'(Ack), 32'(cur_t == 5 && m_kind == 1));
        check("rvalid", 32'(RValid), 32'(cur_t == 0 && m_kind == 1 && m_aux && !m_we));
        check("rdata", 32'(RData), 32'(m_rdata));
        check("vvalid", 32'(VValid), 32'(cur_t == 9));
        check("vdata", 32'(VData), 32'(m_vdata));
        check("cmdbusy", 32'(CmdBusy), 32'(m_busy));
        check("cmddone", 32'(CmdDone), 32'(m_done));
    endtask

    task automatic tick();
        logic was_reset;
        VA   = 16'($urandom);
        Vout = 8'($urandom);
        Dout = dout_force ? dout_val : 8'($urandom);
        was_reset = Reset;
        if (was_reset) model_reset();
        else model_step();
        @(posedge C14M);
        @(negedge C14M);
        n = was_reset ? 0 : n + 1;
        cur_t = phase_t(n);
        if (was_reset) check_reset();
        else begin
            check_outputs();
            if (cur_t == 5 && nWE === 1'b0 && nC07X === 1'b0) seq_obs.push_back(Din);
        end
    endtask

    task automatic cpu_req(input logic we, input logic aux, input logic [15:0] a,
                           input logic [7:0] d, output int lat);
        Req = 1'b1; ReqWE = we; ReqAux = aux; ReqA = a; ReqD = d;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Ack === 1'b1) begin lat = i + 1; break; end
        end
        Req = 1'b0;
        check("ack_seen", 32'(lat > 0), 1);
    endtask

    task automatic run_cmd(input logic [7:0] cb, input logic [7:0] ca, input logic ha,
                           output bit got_done, output int acks);
        m_seq_writes = 0;
        seq_obs.delete();
        CmdReq = 1'b1; CmdByte = cb; CmdArg = ca; CmdHasArg = ha;
        tick();
        CmdReq = 1'b0;
        got_done = 1'b0; acks = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i == 20) begin CmdReq = 1'b1; CmdByte = 8'h11; end
            if (i == 21) CmdReq = 1'b0;
            if (Ack === 1'b1) acks++;
            if (CmdDone === 1'b1) begin got_done = 1'b1; break; end
        end
        check("cmd_done_seen", 32'(got_done), 1);
        check("done_in_t13", 32'(cur_t), 13);
    endtask

    initial begin
        int lat, rv, low, min_low, max_low, acks, dones;
        bit got, hit;
        logic [7:0] exp_seq [8];
        logic [7:0] rb;

        Reset = 1'b1; Req = 1'b0; ReqWE = 1'b0; ReqAux = 1'b0; ReqA = '0; ReqD = '0;
        CmdReq = 1'b0; CmdByte = '0; CmdArg = '0; CmdHasArg = 1'b0;
        VA = '0; Vout = '0; Dout = '0;
        m_seq_writes = 0;
        model_reset();
        repeat (3) tick();
        Reset = 1'b0;

        // first PHI1 rise, then low-phase lengths across a full 65-cycle frame
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (PHI1 === 1'b1) begin lat = i + 1; break; end
        end
        check("first_phi1_rise", 32'(lat), 7);
        low = 0; min_low = 99; max_low = 0;
        repeat (1000) begin
            tick();
            if (PHI1 === 1'b0) low++;
            else if (low != 0) begin
                if (low < min_low) min_low = low;
                if (low > max_low) max_low = low;
                low = 0;
            end
        end
        check("phi1_low_normal", 32'(min_low), 7);
        check("phi1_low_long", 32'(max_low), LONG ? 9 : 7);

        // aux write
        cpu_req(1'b1, 1'b1, 16'h1234, 8'h5A, lat);
        check("aux_wr_ack_t5", 32'(cur_t), 5);
        repeat (12) tick();

        // aux read with card returning C3
        dout_force = 1'b1; dout_val = 8'hC3;
        cpu_req(1'b0, 1'b1, 16'h0400, 8'h00, lat);
        rv = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (RValid === 1'b1) begin rv = i + 1; break; end
        end
        check("ack_to_rvalid", 32'(rv), 9);
        check("aux_rd_data", 32'(RData), 32'hC3);
        dout_force = 1'b0;

        // random CPU traffic, some hitting $C07x
        for (int k = 0; k < 24; k++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = {12'hC07, 4'($urandom)};
            cpu_req(1'($urandom), 1'($urandom), a, 8'($urandom), lat);
            repeat ($urandom_range(0, 20)) tick();
        end

        // command with argument, with a CPU request pending throughout
        Req = 1'b1; ReqWE = 1'b0; ReqAux = 1'b0; ReqA = 16'h2000; ReqD = 8'h00;
        run_cmd(8'hE0, 8'h7F, 1'b1, got, acks);
        check("no_ack_while_busy", 32'(acks), 0);
        exp_seq = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD, 8'hE0, 8'h7F};
        check("seq_write_count", 32'(seq_obs.size()), 8);
        if (seq_obs.size() == 8)
            foreach (exp_seq[i]) check($sformatf("seq_byte%0d", i), 32'(seq_obs[i]), 32'(exp_seq[i]));
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Ack === 1'b1) begin lat = i + 1; break; end
        end
        Req = 1'b0;
        check("ack_after_done_seen", 32'(lat > 0 && lat <= 8), 1);
        check("ack_after_done_t5", 32'(cur_t), 5);
        repeat (10) tick();

        // command without argument
        rb = 8'($urandom);
        run_cmd(rb, 8'h00, 1'b0, got, acks);
        check("seq_noarg_count", 32'(seq_obs.size()), 7);
        if (seq_obs.size() == 7) check("seq_noarg_cmd", 32'(seq_obs[6]), 32'(rb));
        repeat (5) tick();

        // reset during T9 of the third sequence write
        m_seq_writes = 0;
        CmdReq = 1'b1; CmdByte = 8'hEF; CmdArg = 8'h00; CmdHasArg = 1'($urandom);
        tick();
        CmdReq = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_seq_writes == 3 && cur_t == 9) begin hit = 1'b1; break; end
            tick();
        end
        check("reached_write3_t9", 32'(hit), 1);
        check("write3_strobe_low", 32'(nWE), 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        dones = 0;
        repeat (150) begin
            tick();
            if (CmdDone === 1'b1) dones++;
        end
        check("no_done_after_reset", 32'(dones), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram2e_host.md
# ram2e_host

Apple IIe auxiliary-slot bus initiator that drives a RAM2E card under test (FPGA test fixture or simulation). It generates PHI1 and, per Apple cycle, the multiplexed video and CPU addresses (Ain), control strobes and write data. It captures the card's Dout/Vout. A built-in sequencer emits the RAMWorks command sequence to $C073.

## Interface
Parameters:
- LONG_CYCLE, 1, when 1 every 65th Apple cycle is stretched from 14 to 16 C14M cycles

Ports:
- C14M  in  1  14.318 MHz clock, sole clock
- Reset  in  1  synchronous, active-high reset
- PHI1  out  1  Apple PHI1 (high = video phase)
- Ain  out  8  multiplexed DRAM address to card
- Din  out  8  6502 data to card
- nEN80, nWE80, nWE, nC07X  out  1 each  card control strobes, active low
- Dout  in  8  card 6502 read data
- Vout  in  8  card video data
- VA  in  16  next video address
- VData  out  8  captured video byte
- VValid  out  1  VData strobe, 1 cycle
- Req  in  1  CPU access request (level)
- ReqWE  in  1  1 = write
- ReqAux  in  1  1 = aux (EN80) access
- ReqA  in  16  CPU address
- ReqD  in  8  write data
- Ack  out  1  request accepted, 1 cycle
- RData  out  8  aux read data
- RValid  out  1  RData strobe, 1 cycle
- CmdReq  in  1  start command sequence
- CmdByte  in  8  command byte (e.g. E0, EA, EE, EF, FF)
- CmdArg  in  8  argument byte
- CmdHasArg  in  1  1 = send CmdArg as 8th write
- CmdBusy  out  1  sequencer active
- CmdDone  out  1  sequence finished, 1 cycle

## Operation
- Phase counter T runs 0..13, or 0..15 on a long cycle. An Apple-cycle counter runs 0..64; cycle 64 is long when LONG_CYCLE=1.
- All outputs are registered. Values below hold during state T.
- PHI1: 1 for T0..T6, 0 for T7..T15.
- Ain by phase:
  - T13..T15 and T0: video row, VA[7:0]
  - T1..T4: video column, VA[15:8]
  - T5..T7: CPU row, A[7:0]
  - T8..T12: CPU column, A[15:8]
  - VA is latched at the edge ending T12.
- Slot decision happens at the edge ending T4:
  - Sequencer active: it owns the slot.
  - Otherwise, Req=1: latch ReqA/ReqD/ReqWE/ReqAux and pulse Ack during T5.
  - Otherwise: the slot is idle.
- Active slot, T5..T12:
  - nWE = ~WE
  - nEN80 = ~Aux
  - nWE80 = ~(Aux & WE)
  - nC07X = 0 iff A[15:4]==12'hC07
  - Din = write data (0x00 on reads)
- Idle slot, or outside T5..T12: strobes high, Din=0x00.
- Aux read: RData <= Dout at the edge ending T13; RValid=1 during the following T0. Non-aux reads: Ack only.
- Video: VData <= Vout at the edge ending T8; VValid=1 during T9, every Apple cycle.
- Sequencer states:
  - IDLE: CmdReq=1 latches CmdByte/CmdArg/CmdHasArg and moves to SEQ(k=0). CmdBusy=1 from the next cycle.
  - SEQ(k): owns consecutive slots. Each slot writes $C073 (nWE=0, nC07X=0, nEN80=1, nWE80=1). Byte k is, in order: FF, 00, 55, AA, C1, AD, CmdByte, then CmdArg (k=7, only if HasArg).
  - Finish: after the last slot's edge ending T12, CmdBusy=0 and CmdDone=1 during T13; return to IDLE.
- CmdReq while busy: ignored.
- Req while busy: not Acked; held off until the sequencer is IDLE.
- CmdReq and Req arriving together before T4: the sequencer wins.
- Side effect: sequence writes also load the card bank register. The host rewrites the bank afterward.

## Timing
- Reset values:
  - T=7, Apple-cycle counter 0, sequencer IDLE
  - PHI1=0, Ain=0x00, Din=0x00, all strobes 1
  - Ack, RValid, VValid, CmdBusy, CmdDone = 0
  - RData, VData = 0x00
- First PHI1 rise is 7 cycles after Reset deasserts.
- Reset mid-slot or mid-sequence aborts it: no Ack/RValid/CmdDone afterward.
- Req-to-Ack latency: up to one Apple cycle (14–16 clocks).
- Ack-to-RValid: 9 clocks.
- Sequence duration: 7 or 8 back-to-back Apple cycles. There is no idle slot between writes, which keeps the card's 8-cycle command timeout from expiring.
- Long cycle: T14, T15 inserted after T13. PHI1=0 and Ain=video row throughout.

## Test plan
- Reset, release -> PHI1 low 7 clocks, then 7 high / 7 low. With LONG_CYCLE=1, cycle 64 is 16 clocks, 9 low.
- Req aux write A=0x1234, D=0x5A -> Ack in T5; Ain=0x34 in T5..T7, 0x12 in T8..T12; nWE80=0, nEN80=0, Din=0x5A over T5..T12.
- Aux read A=0x0400, Dout model returns 0xC3 -> RData=0xC3, RValid during T0, 9 clocks after Ack.
- CmdReq CmdByte=0xE0, CmdArg=0x7F, HasArg=1 -> 8 consecutive $C073 writes FF,00,55,AA,C1,AD,E0,7F; CmdDone in the 8th cycle's T13.
- Req asserted while CmdBusy -> no Ack until CmdDone; Ack in the next cycle's T5.
- Reset asserted at T9 of sequence write 3 -> strobes high next cycle, CmdBusy=0, no CmdDone.
